vga_sync_gen: RTL

//  Generates 640x480@60 VGA timing: pixel tick, hsync/vsync, video_on and the pixel_x/pixel_y coordinates.

---
 rtl/vga_sync_gen_pkg.sv | 37 +++
 rtl/vga_axis_counter.sv | 66 ++++++
 rtl/vga_sync_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_pkg.sv
// ----------------------------------------------------------------------------
// vga_sync_gen_pkg
// Shared 640x480@60 timing constants for the VGA sync generator and its axis
// counters: display/porch/sync widths, line and frame totals, coordinate
// width, default pixel divider and blink period, plus a small width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package vga_sync_gen_pkg;

    // Coordinate width. Both totals must fit, i.e. be <= 1024.
    localparam int COORD_W = 10;

    // Horizontal timing, in pixels.
    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    // Vertical timing, in lines.
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // 100 MHz system clock -> 25 MHz pixel rate.
    localparam int CLK_DIV_DEF      = 4;
    // Frames per cursor blink half-period (1 Hz blink at 60 fps).
    localparam int BLINK_FRAMES_DEF = 30;

    // Register width needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis (horizontal or vertical) of the VGA raster. Counts
// 0..TOTAL-1 on each inc and wraps; sync_n and active are registered decodes
// of the value being loaded, so they switch on the same edge as count.
// Reset parks the counter on its last position (in blanking).
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active-low
//   inc      in   advance the counter on this edge
//   count    out  current position, 0..TOTAL-1
//   wrap     out  combinational: inc while count==TOTAL-1 (next edge goes to 0)
//   sync_n   out  registered, low inside the sync pulse window
//   active   out  registered, high while count < DISPLAY
// ----------------------------------------------------------------------------
module vga_axis_counter
    import vga_sync_gen_pkg::*;
#(
    parameter int DISPLAY = H_DISPLAY_DEF,
    parameter int FRONT   = H_FRONT_DEF,
    parameter int SYNC    = H_SYNC_DEF,
    parameter int BACK    = H_BACK_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inc,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               sync_n,
    output logic               active
);

    localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;

    localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] DISP_END   = COORD_W'(DISPLAY);
    localparam logic [COORD_W-1:0] SYNC_FIRST = COORD_W'(DISPLAY + FRONT);
    localparam logic [COORD_W-1:0] SYNC_LAST  = COORD_W'(DISPLAY + FRONT + SYNC - 1);

    logic [COORD_W-1:0] count_nxt;

    assign wrap = inc && (count == LAST);

    always_comb begin
        count_nxt = count;
        if (wrap) begin
            count_nxt = '0;
        end else if (inc) begin
            count_nxt = count + COORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= LAST;
            sync_n <= 1'b1;
            active <= 1'b0;
        end else if (inc) begin
            count  <= count_nxt;
            sync_n <= !((count_nxt >= SYNC_FIRST) && (count_nxt <= SYNC_LAST));
            active <= (count_nxt < DISP_END);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
// 640x480@60 VGA timing generator. Divides the system clock down to a pixel
// tick, runs the horizontal/vertical axis counters and registers the sync,
// video_on and frame_start outputs on the same edge as the coordinates.
//
// Build option
//   VGA_BLINK_EN  defined  : frame counter toggles parpadeo every BLINK_FRAMES
//                            entries to (0,0) (reset value 0).
//                 undefined: no frame counter; parpadeo is held at 1.
//
// Ports
//   clk          in   system clock (100 MHz)
//   reset_n      in   asynchronous reset, active-low
//   p_tick       out  one-clk pulse every CLK_DIV clks
//   pixel_x      out  current column, 0..H_TOTAL-1
//   pixel_y      out  current line,   0..V_TOTAL-1
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   video_on     out  high inside the visible area
//   frame_start  out  high while the coordinates are (0,0)
//   parpadeo     out  cursor blink flag for the text layer
// ----------------------------------------------------------------------------
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV      = CLK_DIV_DEF,
    parameter int H_DISPLAY    = H_DISPLAY_DEF,
    parameter int H_FRONT      = H_FRONT_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BACK       = H_BACK_DEF,
    parameter int V_DISPLAY    = V_DISPLAY_DEF,
    parameter int V_FRONT      = V_FRONT_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BACK       = V_BACK_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_start,
    output logic               parpadeo
);

    // ------------------------------------------------------------------
    // Pixel divider
    // ------------------------------------------------------------------
    localparam int                 DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;

    assign div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);

    // p_tick is decoded from the value div is about to take, so it is high
    // exactly during the clk in which div==CLK_DIV-1. With CLK_DIV=1 div
    // stays 0 and p_tick stays high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            p_tick <= 1'b0;
        end else begin
            div    <= div_nxt;
            p_tick <= (div_nxt == DIV_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Axis counters
    // ------------------------------------------------------------------
    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (p_tick),
        .count   (pixel_x),
        .wrap    (h_wrap),
        .sync_n  (hsync),
        .active  (h_active)
    );

    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (h_wrap),
        .count   (pixel_y),
        .wrap    (v_wrap),
        .sync_n  (vsync),
        .active  (v_active)
    );

    // ------------------------------------------------------------------
    // video_on / frame_start
    // ------------------------------------------------------------------
    // video_on is its own flop (not h_active & v_active) so it cannot glitch.
    // Its next value is derived from each axis's current activity: an axis
    // stays active on a step unless it is leaving its last visible position,
    // and it becomes active only by wrapping to 0. The vertical axis only
    // moves on h_wrap.
    localparam logic [COORD_W-1:0] H_LAST_VIS = COORD_W'(H_DISPLAY - 1);
    localparam logic [COORD_W-1:0] V_LAST_VIS = COORD_W'(V_DISPLAY - 1);

    logic h_on_nxt;
    logic v_on_nxt;

    assign h_on_nxt = h_wrap || (h_active && (pixel_x != H_LAST_VIS));
    assign v_on_nxt = v_wrap || (v_active && !(h_wrap && (pixel_y == V_LAST_VIS)));

    // v_wrap can only be high together with p_tick, so it marks the edge
    // that enters (0,0); frame_start then holds for that whole pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else if (p_tick) begin
            video_on    <= h_on_nxt && v_on_nxt;
            frame_start <= v_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Cursor blink
    // ------------------------------------------------------------------
`ifdef VGA_BLINK_EN
    localparam int               FR_W    = cnt_width(BLINK_FRAMES);
    localparam logic [FR_W-1:0]  FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0] frame_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            parpadeo  <= 1'b0;
        end else if (v_wrap) begin
            if (frame_cnt == FR_LAST) begin
                frame_cnt <= '0;
                parpadeo  <= !parpadeo;
            end else begin
                frame_cnt <= frame_cnt + FR_W'(1);
            end
        end
    end
`else
    // Without blinking the cursor is always shown; any legal BLINK_FRAMES
    // (>= 1) yields a constant 1 here.
    assign parpadeo = (BLINK_FRAMES >= 1);
`endif

endmodule
